// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the LSU AXI-Lite master.
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD, 2'b11 behaves as word)
//   - FSM state encoding
//   - byte-strobe and misalignment helpers
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R
    } lsu_state_e;

    // Byte strobes for a store; half uses addr[1] only, so a halfword
    // store never straddles the word.
    function automatic logic [3:0] calc_wstrb(input logic [1:0] size, input logic [1:0] addr);
        case (size)
            SZ_BYTE: return 4'b0001 << addr;
            SZ_HALF: return 4'b0011 << {addr[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr[0];
            default: return addr != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load-data lane select and extension.
//   rdata_in  - raw 32-bit word from the R channel
//   addr      - byte offset within the word
//   size      - access size (lsu_pkg encodings)
//   uns       - 1: zero-extend, 0: sign-extend
//   rdata_out - right-justified, extended result
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_in,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] rdata_out
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (addr)
            2'd0:    byte_v = rdata_in[7:0];
            2'd1:    byte_v = rdata_in[15:8];
            2'd2:    byte_v = rdata_in[23:16];
            default: byte_v = rdata_in[31:24];
        endcase
        half_v = addr[1] ? rdata_in[31:16] : rdata_in[15:0];

        case (size)
            SZ_BYTE: rdata_out = {{24{~uns & byte_v[7]}}, byte_v};
            SZ_HALF: rdata_out = {{16{~uns & half_v[15]}}, half_v};
            default: rdata_out = rdata_in;
        endcase
    end

endmodule

// File: rtl/lsu_axi_lite_master.sv
// lsu_axi_lite_master: CPU load/store to AXI-Lite master bridge.
// One request at a time; stores run AW -> W -> B, loads run AR -> R.
// Ports:
//   clk, resetn (async, active-low)
//   i_req/i_we/i_size/i_unsigned/i_addr/i_wdata : request (sampled in IDLE)
//   o_rdata, o_done, o_busy, o_misalign          : completion side
//   o_axi_* / i_axi_*                            : AXI-Lite master channels
// Build option: LSU_MISALIGN_TRAP_EN - when defined, misaligned requests are
// rejected with o_done+o_misalign and no bus traffic; otherwise the address
// low bits are forced to the size alignment and o_misalign is tied 0.
module lsu_axi_lite_master
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_done,
    output logic                  o_busy,
    output logic                  o_misalign,
    output logic [ADDR_WIDTH-1:0] o_axi_awaddr,
    output logic                  o_axi_awvalid,
    input  logic                  i_axi_awready,
    output logic [DATA_WIDTH-1:0] o_axi_wdata,
    output logic [3:0]            o_axi_wstrb,
    output logic                  o_axi_wvalid,
    input  logic                  i_axi_wready,
    input  logic                  i_axi_bvalid,
    output logic                  o_axi_bready,
    output logic [ADDR_WIDTH-1:0] o_axi_araddr,
    output logic                  o_axi_arvalid,
    input  logic                  i_axi_arready,
    input  logic [DATA_WIDTH-1:0] i_axi_rdata,
    input  logic                  i_axi_rvalid,
    output logic                  o_axi_rready
);

    lsu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, al_addr;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  done_q, done_d;
    logic [31:0]           load_val;
`ifdef LSU_MISALIGN_TRAP_EN
    logic                  misalign_q, misalign_d;
`endif

    // Extraction uses the captured (aligned) address and size, which are
    // held for the whole read.
    lsu_load_align u_load_align (
        .rdata_in  (i_axi_rdata),
        .addr      (addr_q[1:0]),
        .size      (size_q),
        .uns       (uns_q),
        .rdata_out (load_val)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_d = 1'b0;
`endif

        al_addr = i_addr;
        case (i_size)
            SZ_BYTE: ;
            SZ_HALF: al_addr[0]   = 1'b0;
            default: al_addr[1:0] = 2'b00;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (i_req) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    if (is_misaligned(i_size, i_addr[1:0])) begin
                        done_d     = 1'b1;
                        misalign_d = 1'b1;
                    end else
`endif
                    begin
                        addr_d  = al_addr;
                        size_d  = i_size;
                        uns_d   = i_unsigned;
                        wstrb_d = calc_wstrb(i_size, i_addr[1:0]);
                        case (i_size)
                            SZ_BYTE: wdata_d = {4{i_wdata[7:0]}};
                            SZ_HALF: wdata_d = {2{i_wdata[15:0]}};
                            default: wdata_d = i_wdata;
                        endcase
                        state_d = i_we ? ST_AW : ST_AR;
                    end
                end
            end
            ST_AW: if (i_axi_awready) state_d = ST_W;
            ST_W:  if (i_axi_wready)  state_d = ST_B;
            ST_B: begin
                if (i_axi_bvalid) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_AR: if (i_axi_arready) state_d = ST_R;
            ST_R: begin
                if (i_axi_rvalid) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    rdata_d = load_val;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    // Addresses come straight from the capture register so they stay put
    // for the whole transaction (the slave decodes araddr combinationally).
    assign o_axi_awaddr  = addr_q;
    assign o_axi_araddr  = addr_q;
    assign o_axi_wdata   = wdata_q;
    assign o_axi_wstrb   = wstrb_q;
    assign o_axi_awvalid = (state_q == ST_AW);
    assign o_axi_wvalid  = (state_q == ST_W);
    assign o_axi_bready  = (state_q == ST_B);
    assign o_axi_arvalid = (state_q == ST_AR);
    assign o_axi_rready  = (state_q == ST_R);
    assign o_busy        = (state_q != ST_IDLE);
    assign o_done        = done_q;
    assign o_rdata       = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign o_misalign    = misalign_q;
`else
    assign o_misalign    = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_axi_lite_master.sv
module tb_lsu_axi_lite_master;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        i_req = 1'b0, i_we = 1'b0, i_unsigned = 1'b0;
    logic [1:0]  i_size = 2'b00;
    logic [31:0] i_addr = '0, i_wdata = '0;
    logic [31:0] o_rdata, o_axi_awaddr, o_axi_wdata, o_axi_araddr, i_axi_rdata;
    logic        o_done, o_busy, o_misalign;
    logic        o_axi_awvalid, i_axi_awready, o_axi_wvalid, i_axi_wready;
    logic        i_axi_bvalid, o_axi_bready, o_axi_arvalid, i_axi_arready;
    logic        i_axi_rvalid, o_axi_rready;
    logic [3:0]  o_axi_wstrb;

    always #5 clk = ~clk;

    lsu_axi_lite_master dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_we(i_we), .i_size(i_size), .i_unsigned(i_unsigned),
        .i_addr(i_addr), .i_wdata(i_wdata),
        .o_rdata(o_rdata), .o_done(o_done), .o_busy(o_busy), .o_misalign(o_misalign),
        .o_axi_awaddr(o_axi_awaddr), .o_axi_awvalid(o_axi_awvalid), .i_axi_awready(i_axi_awready),
        .o_axi_wdata(o_axi_wdata), .o_axi_wstrb(o_axi_wstrb), .o_axi_wvalid(o_axi_wvalid),
        .i_axi_wready(i_axi_wready), .i_axi_bvalid(i_axi_bvalid), .o_axi_bready(o_axi_bready),
        .o_axi_araddr(o_axi_araddr), .o_axi_arvalid(o_axi_arvalid), .i_axi_arready(i_axi_arready),
        .i_axi_rdata(i_axi_rdata), .i_axi_rvalid(i_axi_rvalid), .o_axi_rready(o_axi_rready)
    );

    // ---------------- slave model with programmable wait states ----------------
    logic [31:0] mem [0:1023];
    int          aw_stall = 0, w_stall = 0, r_stall = 0;
    int          aw_wait, w_wait, r_wait;
    logic        b_pend, r_pend;
    logic [31:0] aw_lat;

    assign i_axi_awready = o_axi_awvalid && (aw_wait >= aw_stall);
    assign i_axi_wready  = o_axi_wvalid && (w_wait >= w_stall);
    assign i_axi_arready = o_axi_arvalid;
    assign i_axi_bvalid  = b_pend;
    assign i_axi_rvalid  = r_pend && (r_wait >= r_stall);
    assign i_axi_rdata   = mem[o_axi_araddr[11:2]];

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_wait <= 0; w_wait <= 0; r_wait <= 0;
            b_pend <= 1'b0; r_pend <= 1'b0; aw_lat <= '0;
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else begin
            if (o_axi_awvalid) aw_wait <= i_axi_awready ? 0 : aw_wait + 1;
            if (o_axi_awvalid && i_axi_awready) aw_lat <= o_axi_awaddr;
            if (o_axi_wvalid) w_wait <= i_axi_wready ? 0 : w_wait + 1;
            if (o_axi_wvalid && i_axi_wready) begin
                b_pend <= 1'b1;
                for (int k = 0; k < 4; k++)
                    if (o_axi_wstrb[k]) mem[aw_lat[11:2]][8*k +: 8] <= o_axi_wdata[8*k +: 8];
            end
            if (b_pend && o_axi_bready) b_pend <= 1'b0;
            if (o_axi_arvalid && i_axi_arready) r_pend <= 1'b1;
            if (r_pend) begin
                if (i_axi_rvalid && o_axi_rready) begin
                    r_pend <= 1'b0;
                    r_wait <= 0;
                end else r_wait <= r_wait + 1;
            end
        end
    end

    // ---------------- bus monitor ----------------
    int          done_cnt = 0, mis_cnt = 0, aw_hs = 0, ar_hs = 0, arv_cnt = 0;
    int          unstable = 0, drops = 0;
    logic [31:0] aw_seen = '0, ar_seen = '0, wd_seen = '0;
    logic [3:0]  ws_seen = '0;
    logic        awv_p = 0, awr_p = 0, wv_p = 0, wr_p = 0, arv_p = 0, arr_p = 0;
    logic        awtrk = 0, artrk = 0;
    logic [31:0] awa_p = '0, ara_p = '0;

    always @(posedge clk) begin
        if (o_done) done_cnt <= done_cnt + 1;
        if (o_misalign) mis_cnt <= mis_cnt + 1;
        if (o_axi_arvalid) arv_cnt <= arv_cnt + 1;
        if (o_axi_awvalid && i_axi_awready) begin aw_hs <= aw_hs + 1; aw_seen <= o_axi_awaddr; end
        if (o_axi_wvalid && i_axi_wready) begin wd_seen <= o_axi_wdata; ws_seen <= o_axi_wstrb; end
        if (o_axi_arvalid && i_axi_arready) begin ar_hs <= ar_hs + 1; ar_seen <= o_axi_araddr; end
        // a valid withdrawn before its handshake
        if (resetn && ((awv_p && !awr_p && !o_axi_awvalid) || (wv_p && !wr_p && !o_axi_wvalid) ||
                       (arv_p && !arr_p && !o_axi_arvalid)))
            drops <= drops + 1;
        awv_p <= o_axi_awvalid; awr_p <= i_axi_awready;
        wv_p  <= o_axi_wvalid;  wr_p  <= i_axi_wready;
        arv_p <= o_axi_arvalid; arr_p <= i_axi_arready;
        if (o_axi_awvalid || o_axi_wvalid || o_axi_bready) begin
            if (awtrk && o_axi_awaddr != awa_p) unstable <= unstable + 1;
            awa_p <= o_axi_awaddr; awtrk <= 1'b1;
        end else awtrk <= 1'b0;
        if (o_axi_arvalid || o_axi_rready) begin
            if (artrk && o_axi_araddr != ara_p) unstable <= unstable + 1;
            ara_p <= o_axi_araddr; artrk <= 1'b1;
        end else artrk <= 1'b0;
    end

    // ---------------- checking helpers ----------------
    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic mis, output int lat);
        int  n;
        logic ok;
        n = 0;
        while (o_busy && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        i_req = 1'b1; i_we = we; i_size = size; i_unsigned = uns; i_addr = addr; i_wdata = wdata;
        @(posedge clk);
        #1 i_req = 1'b0;
        lat = 0; ok = 1'b0;
        while (lat < 200 && !ok) begin
            @(negedge clk);
            lat++;
            if (o_done) ok = 1'b1;
        end
        rd = o_rdata; mis = o_misalign;
        chk("op_completes", {31'b0, ok}, 32'd1);
        @(negedge clk);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_strb;
        logic [31:0] exp_rdata;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] ea, input logic [31:0] ew,
                                input logic [3:0] es, input logic [31:0] er);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_addr = ea; v.exp_wdata = ew; v.exp_strb = es; v.exp_rdata = er;
        return v;
    endfunction

    vec_t        vecs [16];
    logic [31:0] rd, last_rd;
    logic        mis;
    int          lat, d0, a0, r0, m0, v0, u0, dr0;

    initial begin
        vecs[0]  = mk(1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 32'h100, 32'hDEADBEEF, 4'b1111, 0);
        vecs[1]  = mk(0, 2'b10, 0, 32'h100, 0, 32'h100, 0, 0, 32'hDEADBEEF);
        vecs[2]  = mk(1, 2'b00, 0, 32'h203, 32'h00000080, 32'h203, 32'h80808080, 4'b1000, 0);
        vecs[3]  = mk(0, 2'b00, 0, 32'h203, 0, 32'h203, 0, 0, 32'hFFFFFF80);
        vecs[4]  = mk(0, 2'b00, 1, 32'h203, 0, 32'h203, 0, 0, 32'h00000080);
        vecs[5]  = mk(1, 2'b10, 0, 32'h300, 32'hCAFEF00D, 32'h300, 32'hCAFEF00D, 4'b1111, 0);
        vecs[6]  = mk(1, 2'b01, 0, 32'h302, 32'hABCD1234, 32'h302, 32'h12341234, 4'b1100, 0);
        vecs[7]  = mk(0, 2'b01, 1, 32'h302, 0, 32'h302, 0, 0, 32'h00001234);
        vecs[8]  = mk(0, 2'b10, 0, 32'h300, 0, 32'h300, 0, 0, 32'h1234F00D);
        vecs[9]  = mk(0, 2'b01, 0, 32'h300, 0, 32'h300, 0, 0, 32'hFFFFF00D);
        vecs[10] = mk(0, 2'b00, 0, 32'h301, 0, 32'h301, 0, 0, 32'hFFFFFFF0);
        vecs[11] = mk(1, 2'b00, 0, 32'h101, 32'h0000005A, 32'h101, 32'h5A5A5A5A, 4'b0010, 0);
        vecs[12] = mk(0, 2'b11, 0, 32'h100, 0, 32'h100, 0, 0, 32'hDEAD5AEF);
        vecs[13] = mk(0, 2'b00, 1, 32'h100, 0, 32'h100, 0, 0, 32'h000000EF);
        vecs[14] = mk(0, 2'b01, 0, 32'h102, 0, 32'h102, 0, 0, 32'hFFFFDEAD);
        vecs[15] = mk(0, 2'b10, 0, 32'h200, 0, 32'h200, 0, 0, 32'h80000000);

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_awvalid", {31'b0, o_axi_awvalid}, 0);
        chk("rst_wvalid",  {31'b0, o_axi_wvalid}, 0);
        chk("rst_arvalid", {31'b0, o_axi_arvalid}, 0);
        chk("rst_readies", {30'b0, o_axi_bready, o_axi_rready}, 0);
        chk("rst_flags",   {29'b0, o_done, o_busy, o_misalign}, 0);
        chk("rst_rdata",   o_rdata, 0);
        chk("rst_addr",    o_axi_awaddr | o_axi_araddr, 0);
        chk("rst_wdata",   {o_axi_wdata[31:4], o_axi_wdata[3:0] | o_axi_wstrb}, 0);
        resetn = 1'b1;

        // table-driven directed vectors
        last_rd = '0;
        for (int i = 0; i < 16; i++) begin
            d0 = done_cnt; a0 = aw_hs; r0 = ar_hs;
            do_op(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, rd, mis, lat);
            chk($sformatf("v%0d_done_once", i), done_cnt - d0, 1);
            chk($sformatf("v%0d_misalign", i), {31'b0, mis}, 0);
            if (vecs[i].we) begin
                chk($sformatf("v%0d_aw_hs", i), aw_hs - a0, 1);
                chk($sformatf("v%0d_awaddr", i), aw_seen, vecs[i].exp_addr);
                chk($sformatf("v%0d_wdata", i), wd_seen, vecs[i].exp_wdata);
                chk($sformatf("v%0d_wstrb", i), {28'b0, ws_seen}, {28'b0, vecs[i].exp_strb});
                chk($sformatf("v%0d_rdata_kept", i), rd, last_rd);
            end else begin
                chk($sformatf("v%0d_ar_hs", i), ar_hs - r0, 1);
                chk($sformatf("v%0d_araddr", i), ar_seen, vecs[i].exp_addr);
                chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
                last_rd = vecs[i].exp_rdata;
            end
        end

        // slave wait states on AW, W and R
        aw_stall = 5; w_stall = 5; r_stall = 5;
        d0 = done_cnt; u0 = unstable; dr0 = drops;
        do_op(1, 2'b10, 0, 32'h400, 32'h11223344, rd, mis, lat);
        chk("stall_st_waited", {31'b0, lat >= 12}, 1);
        chk("stall_st_awaddr", aw_seen, 32'h400);
        do_op(0, 2'b10, 0, 32'h400, 0, rd, mis, lat);
        chk("stall_ld_waited", {31'b0, lat >= 7}, 1);
        chk("stall_ld_rdata", rd, 32'h11223344);
        chk("stall_done_cnt", done_cnt - d0, 2);
        chk("stall_addr_stable", unstable - u0, 0);
        chk("stall_valid_held", drops - dr0, 0);
        last_rd = 32'h11223344;
        aw_stall = 0; w_stall = 0; r_stall = 0;

        // misaligned word load / half store
        d0 = done_cnt; r0 = ar_hs; a0 = aw_hs; m0 = mis_cnt; v0 = arv_cnt;
        do_op(0, 2'b10, 0, 32'h102, 0, rd, mis, lat);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_ld_flag", {31'b0, mis}, 1);
        chk("mis_ld_latency", lat, 1);
        chk("mis_ld_no_arvalid", arv_cnt - v0, 0);
        chk("mis_ld_rdata_kept", rd, last_rd);
        do_op(1, 2'b01, 0, 32'h101, 32'h0000BEEF, rd, mis, lat);
        chk("mis_st_flag", {31'b0, mis}, 1);
        chk("mis_st_no_aw", aw_hs - a0, 0);
        chk("mis_cnt", mis_cnt - m0, 2);
        do_op(0, 2'b10, 0, 32'h100, 0, rd, mis, lat);
        chk("mis_mem_kept", rd, 32'hDEAD5AEF);
`else
        chk("mis_ld_flag", {31'b0, mis}, 0);
        chk("mis_ld_araddr", ar_seen, 32'h100);
        chk("mis_ld_ar_hs", ar_hs - r0, 1);
        chk("mis_ld_rdata", rd, 32'hDEAD5AEF);
        do_op(1, 2'b01, 0, 32'h101, 32'h0000BEEF, rd, mis, lat);
        chk("mis_st_awaddr", aw_seen, 32'h100);
        chk("mis_st_wstrb", {28'b0, ws_seen}, 32'h3);
        chk("mis_cnt", mis_cnt - m0, 0);
        do_op(0, 2'b10, 0, 32'h100, 0, rd, mis, lat);
        chk("mis_mem_word", rd, 32'hDEADBEEF);
`endif
        chk("mis_done_cnt", done_cnt - d0, 3);

        // reset while in W
        w_stall = 8;
        @(negedge clk);
        i_req = 1'b1; i_we = 1'b1; i_size = 2'b10; i_addr = 32'h500; i_wdata = 32'h55AA55AA;
        @(posedge clk);
        #1 i_req = 1'b0;
        begin
            int n;
            n = 0;
            while (!o_axi_wvalid && n < 50) begin @(negedge clk); n++; end
            chk("rstw_reached_w", {31'b0, o_axi_wvalid}, 1);
        end
        d0 = done_cnt;
        resetn = 1'b0;
        #1;
        chk("rstw_awvalid", {31'b0, o_axi_awvalid}, 0);
        chk("rstw_wvalid", {31'b0, o_axi_wvalid}, 0);
        chk("rstw_busy", {31'b0, o_busy}, 0);
        chk("rstw_rdata", o_rdata, 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        w_stall = 0;
        repeat (2) @(negedge clk);
        chk("rstw_no_done", done_cnt - d0, 0);
        do_op(1, 2'b10, 0, 32'h600, 32'h0BADF00D, rd, mis, lat);
        do_op(0, 2'b10, 0, 32'h600, 0, rd, mis, lat);
        chk("rstw_after_load", rd, 32'h0BADF00D);
        chk("rstw_after_done", done_cnt - d0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
